// File: rtl/alu_pkg.sv
// Shared types and default sizes for the ALU issue stage.
// Contents:
//   DwDefault / NregDefault / AwDefault / CntwDefault - default datapath, register-file and
//                                                      counter sizes
//   alu_cmd_e    - 3-bit ALU opcode encoding
//   ex_latch_t   - contents of the EX latch that feeds the ALU
//   ExLatchReset - EX latch value after reset (NOP, zero operands)
package alu_pkg;

  localparam int unsigned DwDefault   = 8;
  localparam int unsigned NregDefault = 8;
  localparam int unsigned AwDefault   = $clog2(NregDefault);
  localparam int unsigned CntwDefault = 16;

  typedef enum logic [2:0] {
    CmdAdd  = 3'b000,
    CmdSub  = 3'b001,
    CmdShr  = 3'b010,
    CmdShl  = 3'b011,
    CmdXor  = 3'b100,
    CmdRxor = 3'b101,
    CmdAnd  = 3'b110,
    CmdNop  = 3'b111
  } alu_cmd_e;

  // Field widths follow the package defaults; the issue stage must be built with matching
  // DW/NREG.
  typedef struct packed {
    alu_cmd_e             cmd;
    logic [DwDefault-1:0] a;
    logic [DwDefault-1:0] b;
    logic                 c;
    logic [AwDefault-1:0] rd;
    logic                 wen;
    logic                 setf;
  } ex_latch_t;

  localparam ex_latch_t ExLatchReset = '{
    cmd:  CmdNop,
    a:    '0,
    b:    '0,
    c:    1'b0,
    rd:   '0,
    wen:  1'b0,
    setf: 1'b0
  };

endpackage

// File: rtl/reg_file.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port.
// Ports:
//   clk_i                  - clock, write on posedge
//   reset_i                - synchronous active-high reset, clears every entry
//   raddr_a_i / rdata_a_o  - read port A
//   raddr_b_i / rdata_b_o  - read port B
//   we_i, waddr_i, wdata_i - write port
// Every entry is writable, r0 included.
module reg_file #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage wrapped around an external combinational ALU.
// Ports:
//   clk, reset                        - clock; synchronous active-high reset
//   in_valid/in_ready                 - decoded-op handshake (in_ready = !stall_i)
//   in_cmd, in_ra, in_rb, in_rd       - opcode and register addresses
//   in_wen, in_setf, in_use_c         - writeback enable, flag update, carry-in select
//   stall_i                           - downstream hold, freezes the EX latch
//   alu_cmd, inA, inB, sc_i           - registered ALU inputs from the EX latch
//   rslt, sc_o, pari, zero            - ALU results, consumed when the EX op retires
//   flag_c, flag_z, flag_p            - architectural flags
//   retired                           - wrapping count of retired ops
// An op is issued into the EX latch one cycle after acceptance and retires on the first
// cycle stall_i is low. Results of the retiring op are forwarded into the op being issued
// on the same edge, so dependent ops run back-to-back without bubbles.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW   = DwDefault,
  parameter int unsigned NREG = NregDefault,
  parameter int unsigned CNTW = CntwDefault,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_cmd,
  input  logic [AW-1:0]   in_ra,
  input  logic [AW-1:0]   in_rb,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_wen,
  input  logic            in_setf,
  input  logic            in_use_c,
  input  logic            stall_i,
  output logic [2:0]      alu_cmd,
  output logic [DW-1:0]   inA,
  output logic [DW-1:0]   inB,
  output logic            sc_i,
  input  logic [DW-1:0]   rslt,
  input  logic            sc_o,
  input  logic            pari,
  input  logic            zero,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_p,
  output logic [CNTW-1:0] retired
);

  ex_latch_t       ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic            flag_c_q, flag_c_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_p_q, flag_p_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic            accept;
  logic            retire;
  logic            rf_we;
  logic [DW-1:0]   rf_a, rf_b;
  logic [DW-1:0]   op_a, op_b;
  logic            carry_in;

  assign in_ready = !stall_i;
  assign accept   = in_valid && in_ready;
  assign retire   = ex_valid_q && !stall_i;
  assign rf_we    = retire && ex_q.wen;

  reg_file #(
    .DW   (DW),
    .NREG (NREG)
  ) u_reg_file (
    .clk_i     (clk),
    .reset_i   (reset),
    .raddr_a_i (in_ra),
    .rdata_a_o (rf_a),
    .raddr_b_i (in_rb),
    .rdata_b_o (rf_b),
    .we_i      (rf_we),
    .waddr_i   (ex_q.rd),
    .wdata_i   (rslt)
  );

  // Operand and carry forwarding from the op retiring on this same edge.
  always_comb begin
    op_a     = (rf_we && (ex_q.rd == in_ra)) ? rslt : rf_a;
    op_b     = (rf_we && (ex_q.rd == in_rb)) ? rslt : rf_b;
    carry_in = in_use_c && ((retire && ex_q.setf) ? sc_o : flag_c_q);
  end

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    flag_p_d   = flag_p_q;
    retired_d  = retired_q;

    if (retire) begin
      ex_valid_d = 1'b0;
      retired_d  = retired_q + CNTW'(1);
      if (ex_q.setf) begin
        flag_c_d = sc_o;
        flag_z_d = zero;
        flag_p_d = pari;
      end
    end

    // Without a new accept the latch keeps its last fields; only ex_valid drops.
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d.cmd   = alu_cmd_e'(in_cmd);
      ex_d.a     = op_a;
      ex_d.b     = op_b;
      ex_d.c     = carry_in;
      ex_d.rd    = in_rd;
      ex_d.wen   = in_wen;
      ex_d.setf  = in_setf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= ExLatchReset;
      ex_valid_q <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_p_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      flag_p_q   <= flag_p_d;
      retired_q  <= retired_d;
    end
  end

  assign alu_cmd = ex_q.cmd;
  assign inA     = ex_q.a;
  assign inB     = ex_q.b;
  assign sc_i    = ex_q.c;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign flag_p  = flag_p_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU drives the DUT's ALU inputs, an
// architectural model (register array, flags, one in-flight op) predicts every output each
// cycle, and directed sequences pin the model with hand-computed literals.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cmd;
  logic [2:0]  in_ra, in_rb, in_rd;
  logic        in_wen, in_setf, in_use_c;
  logic        stall_i;
  logic [2:0]  alu_cmd;
  logic [7:0]  inA, inB;
  logic        sc_i;
  logic [7:0]  rslt;
  logic        sc_o, pari, zero;
  logic        flag_c, flag_z, flag_p;
  logic [15:0] retired;

  // Bench-side ALU override, used to load constants through the writeback path.
  logic        ovr_en;
  logic [7:0]  ovr_val;
  logic        ovr_co;
  logic [8:0]  alu_out;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  alu_issue_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .in_ra    (in_ra),
    .in_rb    (in_rb),
    .in_rd    (in_rd),
    .in_wen   (in_wen),
    .in_setf  (in_setf),
    .in_use_c (in_use_c),
    .stall_i  (stall_i),
    .alu_cmd  (alu_cmd),
    .inA      (inA),
    .inB      (inB),
    .sc_i     (sc_i),
    .rslt     (rslt),
    .sc_o     (sc_o),
    .pari     (pari),
    .zero     (zero),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_p   (flag_p),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry_out, result}.
  function automatic logic [8:0] alu_f(input logic [2:0] cmd, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci);
    logic [8:0] t;
    case (cmd)
      3'd0:    t = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      3'd1:    t = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      3'd2:    t = {a[0], ci, a[7:1]};
      3'd3:    t = {a, ci};
      3'd4:    t = {1'b0, a ^ b};
      3'd5:    t = {8'd0, ^a};
      3'd6:    t = {1'b0, a & b};
      default: t = 9'd0;
    endcase
    return t;
  endfunction

  always_comb begin
    alu_out = ovr_en ? {ovr_co, ovr_val} : alu_f(alu_cmd, inA, inB, sc_i);
  end
  assign rslt = alu_out[7:0];
  assign sc_o = alu_out[8];
  assign zero = (alu_out[7:0] == 8'd0);
  assign pari = ^alu_out[7:0];

  // Architectural model: on each edge the in-flight op (if any) retires into the register
  // array and flags first; the newly accepted op then reads the updated state.
  logic [7:0]  m_rf [8];
  logic        m_c, m_z, m_p;
  logic [15:0] m_cnt;
  logic        m_exv;
  logic [2:0]  m_cmd;
  logic [7:0]  m_a, m_b;
  logic        m_ci;
  logic [2:0]  m_rd;
  logic        m_wen, m_setf;
  logic [8:0]  m_res;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
      {m_c, m_z, m_p} = 3'b000;
      m_cnt = 16'd0;
      m_exv = 1'b0;
      m_cmd = 3'b111;
      m_a = 8'd0;
      m_b = 8'd0;
      m_ci = 1'b0;
      m_rd = 3'd0;
      m_wen = 1'b0;
      m_setf = 1'b0;
    end else if (!stall_i) begin
      if (m_exv) begin
        m_res = ovr_en ? {ovr_co, ovr_val} : alu_f(m_cmd, m_a, m_b, m_ci);
        if (m_wen) m_rf[m_rd] = m_res[7:0];
        if (m_setf) begin
          m_c = m_res[8];
          m_z = (m_res[7:0] == 8'd0);
          m_p = ^m_res[7:0];
        end
        m_cnt = m_cnt + 16'd1;
        m_exv = 1'b0;
      end
      if (in_valid) begin
        m_cmd  = in_cmd;
        m_a    = m_rf[in_ra];
        m_b    = m_rf[in_rb];
        m_ci   = in_use_c & m_c;
        m_rd   = in_rd;
        m_wen  = in_wen;
        m_setf = in_setf;
        m_exv  = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !stall_i});
      chk("alu_cmd",  {29'd0, alu_cmd},  {29'd0, m_cmd});
      chk("inA",      {24'd0, inA},      {24'd0, m_a});
      chk("inB",      {24'd0, inB},      {24'd0, m_b});
      chk("sc_i",     {31'd0, sc_i},     {31'd0, m_ci});
      chk("flags",    {29'd0, flag_c, flag_z, flag_p}, {29'd0, m_c, m_z, m_p});
      chk("retired",  {16'd0, retired},  {16'd0, m_cnt});
    end
  end

  task automatic issue(input logic [2:0] cmd, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd, input logic wen, input logic setf,
                       input logic usec);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_ra    = ra;
    in_rb    = rb;
    in_rd    = rd;
    in_wen   = wen;
    in_setf  = setf;
    in_use_c = usec;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_cmd = 3'd0;
    in_ra = 3'd0;
    in_rb = 3'd0;
    in_rd = 3'd0;
    in_wen = 1'b0;
    in_setf = 1'b0;
    in_use_c = 1'b0;
    stall_i = 1'b0;
    ovr_en = 1'b0;
    ovr_val = 8'd0;
    ovr_co = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_alu_cmd", {29'd0, alu_cmd}, 32'd7);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    // Preload r1=5, r2=3, then ADD r3=r1+r2 and SUB r4=r3-r1 back-to-back.
    ovr_en = 1'b1;
    issue(3'd6, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
    ovr_val = 8'h05;
    issue(3'd6, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
    ovr_val = 8'h03;
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    ovr_en = 1'b0;
    chk("add_inA", {24'd0, inA}, 32'h05);
    chk("add_inB_fwd", {24'd0, inB}, 32'h03);
    issue(3'd1, 3'd3, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("sub_inA_fwd", {24'd0, inA}, 32'h08);
    chk("sub_inB", {24'd0, inB}, 32'h05);
    chk("dep_ready", {31'd0, in_ready}, 32'd1);
    issue(3'd4, 3'd1, 3'd1, 3'd5, 1'b1, 1'b1, 1'b0);
    chk("dep_retired", {16'd0, retired}, 32'd4);
    chk("model_r3", {24'd0, m_rf[3]}, 32'h08);
    chk("model_r4", {24'd0, m_rf[4]}, 32'h03);

    // XOR r1^r1 sets Z=1,P=0; then AND F1&07 sets Z=0,P=1; then a setf=0 op leaves flags.
    issue(3'd6, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("xor_flag_z", {31'd0, flag_z}, 32'd1);
    chk("xor_flag_p", {31'd0, flag_p}, 32'd0);
    ovr_en = 1'b1;
    ovr_val = 8'hF1;
    issue(3'd6, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    ovr_val = 8'h07;
    issue(3'd6, 3'd6, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0);
    ovr_en = 1'b0;
    chk("and_inA", {24'd0, inA}, 32'hF1);
    chk("and_inB_fwd", {24'd0, inB}, 32'h07);
    issue(3'd0, 3'd4, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0);
    chk("and_flags", {29'd0, flag_c, flag_z, flag_p}, 32'b001);
    chk("r0_fwd", {24'd0, inB}, 32'h01);
    chk("model_r0", {24'd0, m_rf[0]}, 32'h01);
    idle();
    chk("nosetf_flags", {29'd0, flag_c, flag_z, flag_p}, 32'b001);
    chk("retired_9", {16'd0, retired}, 32'd9);

    // Carry forwarding from a retiring setf op into a use_c op.
    issue(3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    ovr_en = 1'b1;
    ovr_val = 8'h00;
    ovr_co = 1'b1;
    issue(3'd0, 3'd5, 3'd5, 3'd3, 1'b0, 1'b0, 1'b1);
    ovr_en = 1'b0;
    ovr_co = 1'b0;
    chk("carry_fwd_sc_i", {31'd0, sc_i}, 32'd1);
    chk("carry_flag_c", {31'd0, flag_c}, 32'd1);
    idle();

    // Stall for 3 cycles with EX valid.
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(3'd4, 3'd3, 3'd3, 3'd6, 1'b1, 1'b1, 1'b0);
      chk("stall_inA", {24'd0, inA}, 32'h05);
      chk("stall_inB", {24'd0, inB}, 32'h04);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_retired", {16'd0, retired}, 32'd11);
    end
    stall_i = 1'b0;
    idle();
    chk("unstall_retired", {16'd0, retired}, 32'd12);
    issue(3'd6, 3'd3, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("read_r3", {24'd0, inA}, 32'h09);
    chk("read_r6", {24'd0, inB}, 32'hF1);
    idle();

    // Reset held for 2 cycles while an op is in flight.
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    issue(3'd4, 3'd1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0);
    issue(3'd4, 3'd1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_cmd", {29'd0, alu_cmd}, 32'd7);
    chk("mid_rst_ops", {15'd0, inA, inB, sc_i}, 32'd0);
    chk("mid_rst_flags", {29'd0, flag_c, flag_z, flag_p}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired}, 32'd0);
    reset = 1'b0;
    issue(3'd6, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_r1", {24'd0, inA}, 32'd0);
    chk("mid_rst_r3", {24'd0, inB}, 32'd0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      stall_i  = ($urandom_range(0, 4) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_cmd   = 3'($urandom_range(0, 7));
      in_ra    = 3'($urandom_range(0, 7));
      in_rb    = 3'($urandom_range(0, 7));
      in_rd    = 3'($urandom_range(0, 7));
      in_wen   = 1'($urandom_range(0, 1));
      in_setf  = 1'($urandom_range(0, 1));
      in_use_c = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    stall_i = 1'b0;
    idle();
    for (int r = 0; r < 8; r++) begin
      issue(3'd6, 3'(r), 3'(r), 3'd0, 1'b0, 1'b0, 1'b0);
    end
    idle();

    // Counter wrap: 65536 back-to-back ops leave 65535 retired with one in EX.
    reset = 1'b1;
    idle();
    reset = 1'b0;
    in_valid = 1'b1;
    in_cmd = 3'd7;
    in_wen = 1'b0;
    in_setf = 1'b0;
    in_use_c = 1'b0;
    repeat (65536) @(posedge clk);
    #1;
    chk("retired_ffff", {16'd0, retired}, 32'h0000FFFF);
    idle();
    chk("retired_wrap", {16'd0, retired}, 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
